sic_alu_lock_arbiter: RTL and testbench
=======================================

Name: sic_alu_lock_arbiter

Overview:
- Responder side of the SIC ALU lock protocol. Arbitrates one shared 32-bit ALU among NUM_SICS execution sub-units.
- Each SIC raises req with its issue_id. The arbiter locks the ALU to the oldest requester and returns a grant plus a combinational result.
- The lock is held until the owner pulses release_lock.
- Sits between the SIC array and the single ALU datapath.

Parameters:
- NUM_SICS, 4, number of requesting SICs (>=2).
- ID_WIDTH, 8, issue_id width; ids compare modulo 2^ID_WIDTH.
- TIMEOUT_CYCLES, 8, stale-lock limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_SICS  per-SIC lock request (level; held until commit or abort).
- req_issue_id  in  NUM_SICS*ID_WIDTH  per-SIC issue_id; slot i is bits [i*ID_WIDTH +: ID_WIDTH].
- release_lock  in  NUM_SICS  per-SIC one-cycle release pulse.
- op  in  NUM_SICS*6  per-SIC ALU op (MIPS funct encoding).
- a  in  NUM_SICS*32  per-SIC operand a (shamt in a[4:0] for shifts).
- b  in  NUM_SICS*32  per-SIC operand b.
- grant  out  NUM_SICS  one-hot-or-zero grant.
- ans_c  out  32  ALU result of the current owner.
- ans_zero  out  1  ans_c == 0.
- owner_valid  out  1  lock held.
- owner_idx  out  $clog2(NUM_SICS)  current owner index.

Behaviour:
- State machine has two states:
  - FREE: no owner.
  - LOCKED(owner): owner_valid=1, owner_idx=owner.
- Reset (rst=1 at a clk edge) puts the block in FREE; this applies mid-lock too, and the lock is dropped.
  - Output values while in FREE: grant=0, owner_valid=0, owner_idx=0, ans_c=0, ans_zero=1.
- Age compare: x is older than y iff (x - y) mod 2^ID_WIDTH has its MSB set. Equal ids tie-break to the lower index.
- Winner selection: the oldest among the candidate req bits, chosen combinationally; it takes effect at the next clk edge (one-cycle grant latency).
- FREE transitions:
  - Any req: next state LOCKED(winner over all req).
  - No req: stay in FREE.
- LOCKED(o) transitions:
  - release_lock[o]=1 with another req[j]=1 (j != o): next state LOCKED(winner over req excluding o). This is a back-to-back handoff with no FREE bubble.
  - release_lock[o]=1 and no other req: next state FREE.
  - release_lock[j] for j != o is ignored; an aborting non-owner may pulse release without holding the lock.
  - A younger req never preempts o.
- grant[i] = LOCKED && owner==i && req[i], combinational. If the owner drops req (commit or abort), its grant falls the same cycle while the lock stays held until release.
- ans_c/ans_zero are computed combinationally from op/a/b of owner_idx whenever LOCKED; requesters sample them only while their grant is high.
- ALU ops (32-bit, wrap, no overflow trap):
  - 0x00 SLL: b<<a[4:0].
  - 0x02 SRL: b>>a[4:0].
  - 0x03 SRA: arithmetic right shift of b by a[4:0].
  - 0x20/0x21 ADD/ADDU: a+b.
  - 0x22/0x23 SUB/SUBU: a-b.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x2A SLT: signed a<b ? 1 : 0.
  - 0x2B SLTU: unsigned a<b ? 1 : 0.
  - 0x0F LUI: b<<16.
  - Any other op: 0.
- Simultaneous events:
  - A new req arriving in the same cycle as the owner's release competes in the handoff.
  - A req and release from the same non-owner SIC in one cycle are ignored.

Optional Feature:
- Macro: SIC_ALU_LOCK_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCKED cycle in which req[owner]=0 and release_lock[owner]=0, and clears otherwise.
  - On reaching TIMEOUT_CYCLES, the lock is force-released, using the same handoff/FREE rules as a real release.
  - Extra output timeout_evt (1-bit) pulses for one cycle at the force-release.
- Undefined: no counter and no timeout_evt port; a lock is freed only by release_lock[owner].

Test Plan:
- Reset, then req=4'b0001 with id0=5 -> grant=0 in that cycle; next cycle grant=4'b0001, owner_idx=0. With op=0x20, a=3, b=4 -> ans_c=7, ans_zero=0.
- req=4'b0110 with id1=10, id2=9 -> SIC2 is granted. SIC1 stays ungranted through SIC2's commit (req2 drops, grant=0). Pulse release_lock[2] -> grant=4'b0010 on the next cycle, with no FREE cycle.
- Wrap-around: id0=250, id3=2 (ID_WIDTH=8), both requesting -> SIC0 is granted (250 is older than 2).
- While SIC0 is locked, pulse release_lock[3] from non-owner SIC3 -> owner stays 0 and grant is unchanged.
- Ops on the owner:
  - op=0x03, a=4, b=32'h8000_0000 -> ans_c=32'hF800_0000.
  - op=0x2A, a=32'hFFFF_FFFF, b=1 -> ans_c=1.
  - op=0x23, a=b=9 -> ans_c=0, ans_zero=1.
- Assert rst while LOCKED with req still high -> the next cycle shows owner_valid=0 and grant=0. With the feature defined: owner drops req with no release -> after 8 cycles timeout_evt=1 and the lock passes to the pending requester.

Source files
------------

// File: rtl/sic_alu_lock_arbiter_if.sv
// SIC <-> ALU lock arbiter bus: per-SIC request/operand vectors plus owner/result feedback.
// timeout_evt exists only when SIC_ALU_LOCK_TIMEOUT_EN is defined.
interface sic_alu_lock_arbiter_if #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_SICS);

  logic [NUM_SICS-1:0]          req;
  logic [NUM_SICS*ID_WIDTH-1:0] req_issue_id;
  logic [NUM_SICS-1:0]          release_lock;
  logic [NUM_SICS*6-1:0]        op;
  logic [NUM_SICS*32-1:0]       a;
  logic [NUM_SICS*32-1:0]       b;
  logic [NUM_SICS-1:0]          grant;
  logic [31:0]                  ans_c;
  logic                         ans_zero;
  logic                         owner_valid;
  logic [IDX_W-1:0]             owner_idx;
`ifdef SIC_ALU_LOCK_TIMEOUT_EN
  logic                         timeout_evt;

  modport master (
    output req, req_issue_id, release_lock, op, a, b,
    input  grant, ans_c, ans_zero, owner_valid, owner_idx, timeout_evt
  );
  modport slave (
    input  req, req_issue_id, release_lock, op, a, b,
    output grant, ans_c, ans_zero, owner_valid, owner_idx, timeout_evt
  );
`else
  modport master (
    output req, req_issue_id, release_lock, op, a, b,
    input  grant, ans_c, ans_zero, owner_valid, owner_idx
  );
  modport slave (
    input  req, req_issue_id, release_lock, op, a, b,
    output grant, ans_c, ans_zero, owner_valid, owner_idx
  );
`endif
endinterface

// File: rtl/sic_alu_lock_arbiter.sv
// Locks one shared 32-bit ALU to the oldest requesting SIC until the owner releases it.
// Optional stale-lock timeout: define SIC_ALU_LOCK_TIMEOUT_EN.
module sic_alu_lock_arbiter #(
  parameter int NUM_SICS       = 4,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 8
) (
  input logic                  clk,
  input logic                  rst,
  sic_alu_lock_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SICS);

  typedef enum logic {S_FREE, S_LOCKED} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                locked;
  logic [NUM_SICS-1:0] owner_oh;
  logic [NUM_SICS-1:0] cand;
  logic                own_req, own_rel;
  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;
  logic [ID_WIDTH-1:0] win_id;
  logic                timeout_now;
  logic [5:0]          sel_op;
  logic [31:0]         sel_a, sel_b, alu_res;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Modular age: x is older than y when (x - y) wraps into the upper half.
  function automatic logic is_older(input logic [ID_WIDTH-1:0] x, input logic [ID_WIDTH-1:0] y);
    logic [ID_WIDTH-1:0] d;
    d = x - y;
    return d[ID_WIDTH-1];
  endfunction

  assign locked = (state_q == S_LOCKED);

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_SICS; i++) owner_oh[i] = (owner_q == IDX_W'(i));
  end

  assign own_req = |(bus.req & owner_oh);
  assign own_rel = |(bus.release_lock & owner_oh);

  // A SIC pulsing release while it still requests is aborting, so it cannot win.
  assign cand = bus.req & ~bus.release_lock & (locked ? ~owner_oh : {NUM_SICS{1'b1}});

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_id    = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (cand[i] && (!win_valid || is_older(bus.req_issue_id[i*ID_WIDTH +: ID_WIDTH], win_id))) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_id    = bus.req_issue_id[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

`ifdef SIC_ALU_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle;

  assign idle        = locked && !own_req && !own_rel;
  assign timeout_now = idle && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d       = (idle && !timeout_now) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.timeout_evt = timeout_now;
`else
  assign timeout_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_FREE: begin
        if (win_valid) begin
          state_d = S_LOCKED;
          owner_d = win_idx;
        end
      end
      S_LOCKED: begin
        if (own_rel || timeout_now) begin
          if (win_valid) begin
            owner_d = win_idx;
          end else begin
            state_d = S_FREE;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = S_FREE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FREE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign sel_op = bus.op[int'(owner_q)*6 +: 6];
  assign sel_a  = bus.a[int'(owner_q)*32 +: 32];
  assign sel_b  = bus.b[int'(owner_q)*32 +: 32];

  always_comb begin
    alu_res = 32'd0;
    case (sel_op)
      6'h00:        alu_res = sel_b << sel_a[4:0];
      6'h02:        alu_res = sel_b >> sel_a[4:0];
      6'h03:        alu_res = $unsigned($signed(sel_b) >>> sel_a[4:0]);
      6'h20, 6'h21: alu_res = sel_a + sel_b;
      6'h22, 6'h23: alu_res = sel_a - sel_b;
      6'h24:        alu_res = sel_a & sel_b;
      6'h25:        alu_res = sel_a | sel_b;
      6'h26:        alu_res = sel_a ^ sel_b;
      6'h27:        alu_res = ~(sel_a | sel_b);
      6'h2A:        alu_res = ($signed(sel_a) < $signed(sel_b)) ? 32'd1 : 32'd0;
      6'h2B:        alu_res = (sel_a < sel_b) ? 32'd1 : 32'd0;
      6'h0F:        alu_res = {sel_b[15:0], 16'h0000};
      default:      alu_res = 32'd0;
    endcase
  end

  // owner_valid is the FSM state made visible; grant drops as soon as the owner drops req.
  assign bus.owner_valid = locked;
  assign bus.owner_idx   = owner_q;
  assign bus.grant       = locked ? (bus.req & owner_oh) : '0;
  assign bus.ans_c       = locked ? alu_res : 32'd0;
  assign bus.ans_zero    = (bus.ans_c == 32'd0);
endmodule

// File: tb/tb_sic_alu_lock_arbiter.sv
// Scoreboard bench for sic_alu_lock_arbiter: expected outputs are queued as stimulus is driven
// and checked at the following falling edge.
module tb_sic_alu_lock_arbiter;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int EW = 41; // {grant[4], owner_valid, owner_idx[2], ans_c[32], ans_zero, timeout_evt}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sic_alu_lock_arbiter_if #(.NUM_SICS(N), .ID_WIDTH(IW)) bus ();

  sic_alu_lock_arbiter #(.NUM_SICS(N), .ID_WIDTH(IW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            errors = 0;
  int            checks = 0;
  logic          te_obs;

`ifdef SIC_ALU_LOCK_TIMEOUT_EN
  assign te_obs = bus.timeout_evt;
`else
  assign te_obs = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got grant=%b ov=%b idx=%0d c=%h z=%b te=%b, want grant=%b ov=%b idx=%0d c=%h z=%b te=%b",
               tag, obs[40:37], obs[36], obs[35:34], obs[33:2], obs[1], obs[0],
               exp[40:37], exp[36], exp[35:34], exp[33:2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    string         t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {bus.grant, bus.owner_valid, bus.owner_idx, bus.ans_c, bus.ans_zero, te_obs}, e);
    end
  end

  task automatic expect_out(input string tag, input logic [3:0] g, input logic ov,
                            input logic [1:0] idx, input logic [31:0] c, input logic te = 1'b0);
    exp_q.push_back({g, ov, idx, c, (c == 32'd0), te});
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sic(input int i, input logic r, input logic [7:0] id, input logic [5:0] o,
                         input logic [31:0] av, input logic [31:0] bv);
    bus.req[i]                = r;
    bus.req_issue_id[i*IW +: IW] = id;
    bus.op[i*6 +: 6]          = o;
    bus.a[i*32 +: 32]         = av;
    bus.b[i*32 +: 32]         = bv;
  endtask

  function automatic logic [31:0] alu_ref(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    int          sh;
    sh = int'(x[4:0]);
    r  = 32'd0;
    case (o)
      6'h00: r = y << sh;
      6'h02: r = y >> sh;
      6'h03: begin
        r = y >> sh;
        if (y[31]) for (int k = 0; k < sh; k++) r[31-k] = 1'b1;
      end
      6'h20, 6'h21: r = x + y;
      6'h22, 6'h23: r = x - y;
      6'h24: r = x & y;
      6'h25: r = x | y;
      6'h26: r = x ^ y;
      6'h27: r = ~(x | y);
      6'h2A: r = ((x[31] && !y[31]) || ((x[31] == y[31]) && (x < y))) ? 32'd1 : 32'd0;
      6'h2B: r = (x < y) ? 32'd1 : 32'd0;
      6'h0F: r = y << 16;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [5:0] op_tab[16] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h0F, 6'h3F, 6'h01};

  initial begin
    logic [5:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1;
    bus.req = '0;
    bus.req_issue_id = '0;
    bus.release_lock = '0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("reset_free", 4'b0000, 1'b0, 2'd0, 32'd0); tick();

    set_sic(0, 1'b1, 8'd5, 6'h20, 32'd3, 32'd4);
    expect_out("req0_latency", 4'b0000, 1'b0, 2'd0, 32'd0); tick();
    expect_out("grant0_add", 4'b0001, 1'b1, 2'd0, 32'd7); tick();

    set_sic(0, 1'b1, 8'd5, 6'h03, 32'd4, 32'h8000_0000);
    expect_out("sra", 4'b0001, 1'b1, 2'd0, 32'hF800_0000); tick();
    set_sic(0, 1'b1, 8'd5, 6'h2A, 32'hFFFF_FFFF, 32'd1);
    expect_out("slt_neg", 4'b0001, 1'b1, 2'd0, 32'd1); tick();
    set_sic(0, 1'b1, 8'd5, 6'h23, 32'd9, 32'd9);
    expect_out("subu_zero", 4'b0001, 1'b1, 2'd0, 32'd0); tick();

    for (int k = 0; k < 12; k++) begin
      ro = op_tab[$urandom_range(0, 15)];
      ra = $urandom;
      rb = $urandom;
      set_sic(0, 1'b1, 8'd5, ro, ra, rb);
      expect_out("alu_rand", 4'b0001, 1'b1, 2'd0, alu_ref(ro, ra, rb)); tick();
    end

    set_sic(0, 1'b1, 8'd5, 6'h20, 32'd3, 32'd4);
    bus.release_lock[3] = 1'b1;
    expect_out("nonowner_rel", 4'b0001, 1'b1, 2'd0, 32'd7); tick();
    bus.release_lock[3] = 1'b0;
    expect_out("nonowner_rel_after", 4'b0001, 1'b1, 2'd0, 32'd7); tick();

    bus.req[0] = 1'b0;
    bus.release_lock[0] = 1'b1;
    expect_out("commit_rel0", 4'b0000, 1'b1, 2'd0, 32'd7); tick();
    bus.release_lock[0] = 1'b0;
    expect_out("free_after_rel", 4'b0000, 1'b0, 2'd0, 32'd0); tick();

    set_sic(1, 1'b1, 8'd10, 6'h25, 32'd1, 32'd2);
    set_sic(2, 1'b1, 8'd9, 6'h22, 32'd10, 32'd3);
    expect_out("pair_latency", 4'b0000, 1'b0, 2'd0, 32'd0); tick();
    expect_out("oldest_sic2", 4'b0100, 1'b1, 2'd2, 32'd7); tick();
    bus.req[2] = 1'b0;
    expect_out("commit2", 4'b0000, 1'b1, 2'd2, 32'd7); tick();
    expect_out("commit2_hold", 4'b0000, 1'b1, 2'd2, 32'd7); tick();
    bus.release_lock[2] = 1'b1;
    expect_out("rel2", 4'b0000, 1'b1, 2'd2, 32'd7); tick();
    bus.release_lock[2] = 1'b0;
    expect_out("handoff_sic1", 4'b0010, 1'b1, 2'd1, 32'd3); tick();

    // owner releases while two new requesters arrive; ids wrap around 255
    bus.req[1] = 1'b0;
    bus.release_lock[1] = 1'b1;
    set_sic(0, 1'b1, 8'd250, 6'h20, 32'd3, 32'd4);
    set_sic(3, 1'b1, 8'd2, 6'h0F, 32'd0, 32'h0000_1234);
    expect_out("rel1_with_new", 4'b0000, 1'b1, 2'd1, 32'd3); tick();
    bus.release_lock[1] = 1'b0;
    expect_out("wrap_sic0", 4'b0001, 1'b1, 2'd0, 32'd7); tick();

    bus.req[0] = 1'b0;
    bus.release_lock[0] = 1'b1;
    bus.release_lock[3] = 1'b1;
    expect_out("rel0_abort3", 4'b0000, 1'b1, 2'd0, 32'd7); tick();
    bus.release_lock = '0;
    expect_out("abort3_ignored", 4'b0000, 1'b0, 2'd0, 32'd0); tick();
    expect_out("lui_sic3", 4'b1000, 1'b1, 2'd3, 32'h1234_0000); tick();

    rst = 1'b1;
    expect_out("pre_reset_locked", 4'b1000, 1'b1, 2'd3, 32'h1234_0000); tick();
    rst = 1'b0;
    expect_out("reset_midlock", 4'b0000, 1'b0, 2'd0, 32'd0); tick();
    expect_out("relock_sic3", 4'b1000, 1'b1, 2'd3, 32'h1234_0000); tick();

`ifdef SIC_ALU_LOCK_TIMEOUT_EN
    set_sic(0, 1'b1, 8'd7, 6'h20, 32'd3, 32'd4);
    bus.req[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      expect_out((k == 8) ? "timeout_evt" : "timeout_wait", 4'b0000, 1'b1, 2'd3,
                 32'h1234_0000, (k == 8)); tick();
    end
    expect_out("timeout_handoff", 4'b0001, 1'b1, 2'd0, 32'd7); tick();
`endif

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    check_eq("scoreboard_drain", EW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
